// File: rtl/gpio_int_pkg.sv
// gpio_int_pkg
//   Shared constants for the gpio_int interrupt source banks: register
//   byte offsets, CTRL bit positions and a word-count helper.
package gpio_int_pkg;

   localparam logic [7:0] MASK_BASE   = 8'h00;
   localparam logic [7:0] MODE_BASE   = 8'h20;
   localparam logic [7:0] STATUS_BASE = 8'h40;
   localparam logic [7:0] RAW_BASE    = 8'h60;
   localparam logic [7:0] CTRL_ADDR   = 8'h80;
   localparam logic [7:0] CNT_ADDR    = 8'h84;

   localparam int CTRL_EN_BIT = 0;

   // number of 32-bit register words needed to hold w bits
   function automatic int nwords(int w);
      return (w + 31) / 32;
   endfunction

endpackage

// File: rtl/gpio_int_sync_edge.sv
// gpio_int_sync_edge
//   Vector-wide source conditioning: optional 2-flop synchroniser followed
//   by a history flop used for rising-edge detection.
//   Ports:
//     clk_50m, rstn_50m : clock, async active-low reset
//     src               : raw sources
//     level             : synced source level
//     rise              : one-cycle pulse on a synced 0->1 transition
module gpio_int_sync_edge #(
   parameter int WIDTH   = 1,
   parameter bit SYNC_EN = 1'b1
) (
   input  logic             clk_50m,
   input  logic             rstn_50m,
   input  logic [WIDTH-1:0] src,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] hist;

   generate
      if (SYNC_EN) begin : g_sync
         logic [WIDTH-1:0] meta, stab;
         always_ff @(posedge clk_50m or negedge rstn_50m) begin
            if (!rstn_50m) begin
               meta <= '0;
               stab <= '0;
            end else begin
               meta <= src;
               stab <= meta;
            end
         end
         assign level = stab;
      end else begin : g_nosync
         assign level = src;
      end
   endgenerate

   // History always follows the level regardless of mode, so a later switch
   // to edge mode with the source already high sees no edge.
   always_ff @(posedge clk_50m or negedge rstn_50m) begin
      if (!rstn_50m) hist <= '0;
      else           hist <= level;
   end

   assign rise = level & ~hist;

endmodule

// File: rtl/gpio_int_mask_bank.sv
// gpio_int_mask_bank
//   Interrupt source bank: per-source mask, level/edge mode and sticky
//   status, a global enable, a registered interrupt output and a saturating
//   count of interrupt assertions, all behind a req/ack register port.
//   Ports:
//     clk_50m, rstn_50m : clock, async active-low reset
//     src_i             : raw interrupt sources (active high)
//     cfg_req/we/addr/wdata : register access, one request per cycle
//     cfg_rdata/cfg_ack : read data and completion, one cycle after req
//     int_o             : registered interrupt request
module gpio_int_mask_bank
   import gpio_int_pkg::*;
#(
   parameter int SRC_W   = 48,
   parameter bit SYNC_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk_50m,
   input  logic             rstn_50m,
   input  logic [SRC_W-1:0] src_i,
   input  logic             cfg_req,
   input  logic             cfg_we,
   input  logic [7:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output logic             cfg_ack,
   output logic             int_o
);

   localparam int NW = nwords(SRC_W);
   localparam int PW = NW * 32;

   // address bits [7:5] select the register group, [4:2] the word
   localparam logic [2:0] RGN_MASK   = MASK_BASE[7:5];
   localparam logic [2:0] RGN_MODE   = MODE_BASE[7:5];
   localparam logic [2:0] RGN_STATUS = STATUS_BASE[7:5];
   localparam logic [2:0] RGN_RAW    = RAW_BASE[7:5];

   logic [SRC_W-1:0] mask_q, mode_q, status_q;
   logic [SRC_W-1:0] lvl, rise, set;
   logic             ctrl_en_q;
   logic [CNT_W-1:0] cnt_q;

   logic [PW-1:0] mask_pad, mode_pad, status_pad, raw_pad;
   logic [PW-1:0] mask_wr, mode_wr, clr_pad;
   logic [31:0]   rd_word;
   logic [2:0]    rgn, widx;
   logic          wr, rd, ctrl_sel, cnt_clr, int_next, int_rise;
   logic          unused_bits;

   gpio_int_sync_edge #(
      .WIDTH   (SRC_W),
      .SYNC_EN (SYNC_EN)
   ) u_sync (
      .clk_50m  (clk_50m),
      .rstn_50m (rstn_50m),
      .src      (src_i),
      .level    (lvl),
      .rise     (rise)
   );

   assign wr       = cfg_req & cfg_we;
   assign rd       = cfg_req & ~cfg_we;
   assign rgn      = cfg_addr[7:5];
   assign widx     = cfg_addr[4:2];
   assign ctrl_sel = wr && (cfg_addr[7:2] == CTRL_ADDR[7:2]);
   assign cnt_clr  = wr && (cfg_addr[7:2] == CNT_ADDR[7:2]);

   // Zero-extend state to whole words so bits at or above SRC_W read 0 and
   // writes to them fall off when sliced back to SRC_W.
   always_comb begin
      mask_pad   = '0;
      mode_pad   = '0;
      status_pad = '0;
      raw_pad    = '0;
      mask_pad[SRC_W-1:0]   = mask_q;
      mode_pad[SRC_W-1:0]   = mode_q;
      status_pad[SRC_W-1:0] = status_q;
      raw_pad[SRC_W-1:0]    = lvl;
   end

   // write data merge and read mux
   always_comb begin
      mask_wr = mask_pad;
      mode_wr = mode_pad;
      clr_pad = '0;
      rd_word = '0;
      for (int w = 0; w < NW; w++) begin
         if (widx == 3'(w)) begin
            if (wr && rgn == RGN_MASK)   mask_wr[w*32 +: 32] = cfg_wdata;
            if (wr && rgn == RGN_MODE)   mode_wr[w*32 +: 32] = cfg_wdata;
            if (wr && rgn == RGN_STATUS) clr_pad[w*32 +: 32] = cfg_wdata;
            case (rgn)
               RGN_MASK:   rd_word = mask_pad[w*32 +: 32];
               RGN_MODE:   rd_word = mode_pad[w*32 +: 32];
               RGN_STATUS: rd_word = status_pad[w*32 +: 32];
               RGN_RAW:    rd_word = raw_pad[w*32 +: 32];
               default:    ;
            endcase
         end
      end
      if (cfg_addr[7:2] == CTRL_ADDR[7:2]) rd_word[CTRL_EN_BIT] = ctrl_en_q;
      if (cfg_addr[7:2] == CNT_ADDR[7:2])  rd_word = 32'(cnt_q);
   end

   // per-bit mode select; mask deliberately does not gate capture
   assign set      = (mode_q & rise) | (~mode_q & lvl);
   assign int_next = ctrl_en_q & |(status_q & ~mask_q);
   assign int_rise = int_next & ~int_o;

   always_ff @(posedge clk_50m or negedge rstn_50m) begin
      if (!rstn_50m) begin
         mask_q    <= '1;
         mode_q    <= '0;
         status_q  <= '0;
         ctrl_en_q <= 1'b0;
         cnt_q     <= '0;
         int_o     <= 1'b0;
         cfg_ack   <= 1'b0;
         cfg_rdata <= '0;
      end else begin
         mask_q   <= mask_wr[SRC_W-1:0];
         mode_q   <= mode_wr[SRC_W-1:0];
         // OR-ing set after the clear lets a same-cycle set win over W1C
         status_q <= (status_q & ~clr_pad[SRC_W-1:0]) | set;
         if (ctrl_sel) ctrl_en_q <= cfg_wdata[CTRL_EN_BIT];
         int_o <= int_next;
         if (cnt_clr)                      cnt_q <= '0;
         else if (int_rise && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         cfg_ack   <= cfg_req;
         cfg_rdata <= rd ? rd_word : '0;
      end
   end

   assign unused_bits = ^{cfg_addr[1:0], mask_wr, mode_wr, clr_pad};

endmodule

// File: tb/tb_gpio_int_mask_bank.sv
// tb_gpio_int_mask_bank
//   Directed bench for gpio_int_mask_bank (SRC_W=48, SYNC_EN=1). A second
//   instance with CNT_W=2 shares all inputs to cover counter saturation.
//   A cycle model of the register map runs alongside and is compared every
//   cycle; directed reads also check hand-computed literals.
module tb_gpio_int_mask_bank;

   logic        clk_50m = 1'b0;
   logic        rstn_50m;
   logic [47:0] src_i;
   logic        cfg_req, cfg_we;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata, rdata2;
   logic        cfg_ack, ack2, int_o, int2;

   int total = 0;
   int bad   = 0;

   always #5 clk_50m = ~clk_50m;

   gpio_int_mask_bank #(.SRC_W(48), .SYNC_EN(1'b1), .CNT_W(16)) dut (
      .clk_50m(clk_50m), .rstn_50m(rstn_50m), .src_i(src_i),
      .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_ack(cfg_ack),
      .int_o(int_o));

   gpio_int_mask_bank #(.SRC_W(48), .SYNC_EN(1'b1), .CNT_W(2)) dut2 (
      .clk_50m(clk_50m), .rstn_50m(rstn_50m), .src_i(src_i),
      .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(rdata2), .cfg_ack(ack2),
      .int_o(int2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam logic [63:0] VALID = 64'h0000_FFFF_FFFF_FFFF;
   logic [63:0] m_mask, m_mode, m_status;
   logic [63:0] dly [3];   // src sampled 1, 2, 3 edges back
   logic        m_en, m_int, m_ack;
   logic [31:0] m_rd, m_rd2;
   int unsigned m_cnt, m_cnt2;

   function automatic logic [31:0] word_of(input logic [63:0] v, input int w);
      logic [63:0] t;
      t = v >> (32 * w);
      return t[31:0];
   endfunction

   task automatic model_reset();
      m_mask = VALID; m_mode = '0; m_status = '0;
      m_en = 1'b0; m_int = 1'b0; m_ack = 1'b0; m_rd = '0; m_rd2 = '0;
      m_cnt = 0; m_cnt2 = 0;
      for (int k = 0; k < 3; k++) dly[k] = '0;
   endtask

   task automatic model_step();
      logic [63:0] lvl, prv, set, clr, wsh, dsh;
      logic [31:0] rv, rv2;
      logic        inext, rise, cclr;
      int          w;
      lvl = dly[1];
      prv = dly[2];
      w   = int'(cfg_addr[4:2]);
      set = (m_mode & lvl & ~prv) | (~m_mode & lvl);
      rv  = '0;
      if (w < 2) begin
         case (cfg_addr[7:5])
            3'd0: rv = word_of(m_mask, w);
            3'd1: rv = word_of(m_mode, w);
            3'd2: rv = word_of(m_status, w);
            3'd3: rv = word_of(lvl, w);
            default: ;
         endcase
      end
      if (cfg_addr[7:2] == 6'h20) rv = {31'b0, m_en};
      if (cfg_addr[7:2] == 6'h21) rv = m_cnt;
      rv2   = (cfg_addr[7:2] == 6'h21) ? m_cnt2 : rv;
      inext = m_en && ((m_status & ~m_mask) != 64'd0);
      rise  = inext && !m_int;
      clr   = '0;
      cclr  = 1'b0;
      if (cfg_req && cfg_we) begin
         wsh = 64'hFFFF_FFFF << (32 * w);
         dsh = {32'b0, cfg_wdata} << (32 * w);
         if (w < 2) begin
            case (cfg_addr[7:5])
               3'd0: m_mask = ((m_mask & ~wsh) | dsh) & VALID;
               3'd1: m_mode = ((m_mode & ~wsh) | dsh) & VALID;
               3'd2: clr    = dsh & VALID;
               default: ;
            endcase
         end
         if (cfg_addr[7:2] == 6'h20) m_en = cfg_wdata[0];
         if (cfg_addr[7:2] == 6'h21) cclr = 1'b1;
      end
      m_status = ((m_status & ~clr) | set) & VALID;
      if (cclr) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (rise) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3)    m_cnt2++;
      end
      m_int = inext;
      m_ack = cfg_req;
      m_rd  = (cfg_req && !cfg_we) ? rv  : '0;
      m_rd2 = (cfg_req && !cfg_we) ? rv2 : '0;
      dly[2] = dly[1];
      dly[1] = dly[0];
      dly[0] = {16'b0, src_i};
   endtask

   always @(posedge clk_50m or negedge rstn_50m) begin
      if (!rstn_50m) model_reset();
      else           model_step();
   end

   // every-cycle comparison against the model
   always @(negedge clk_50m) begin
      chk("ack",    32'(cfg_ack), 32'(m_ack));
      chk("rdata",  cfg_rdata,    m_rd);
      chk("int",    32'(int_o),   32'(m_int));
      chk("ack2",   32'(ack2),    32'(m_ack));
      chk("rdata2", rdata2,       m_rd2);
      chk("int2",   32'(int2),    32'(m_int));
   end

   // ---------------- directed stimulus ----------------
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk_50m);
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk_50m);
      cfg_req = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input logic [31:0] e2, input string nm);
      @(negedge clk_50m);
      cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
      @(negedge clk_50m);
      cfg_req = 1'b0;
      chk({nm, "_ack"}, 32'(cfg_ack), 32'd1);
      chk(nm, cfg_rdata, e);
      chk({nm, "_2"}, rdata2, e2);
   endtask

   // pulse one source for a cycle, let int_o rise, then clear it
   task automatic pulse_clear(input int b);
      @(negedge clk_50m); src_i[b] = 1'b1;
      @(negedge clk_50m); src_i[b] = 1'b0;
      repeat (4) @(negedge clk_50m);
      wr(8'h40, 32'd1 << b);
      repeat (2) @(negedge clk_50m);
   endtask

   logic [7:0]  ra [11];
   logic [31:0] re [11];

   initial begin
      rstn_50m = 1'b0; src_i = '0;
      cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      repeat (3) @(negedge clk_50m);
      chk("rst_int", 32'(int_o), 32'd0);
      chk("rst_ack", 32'(cfg_ack), 32'd0);
      chk("rst_rdata", cfg_rdata, 32'd0);
      rstn_50m = 1'b1;

      // reset values of the whole map
      ra = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h24, 8'h40, 8'h44, 8'h60, 8'h64, 8'h80, 8'h84};
      re = '{32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 11; i++) rd(ra[i], re[i], re[i], "rst_read");

      // level mode on bit 0: status at edge 2, int_o at edge 3
      wr(8'h80, 32'd1);
      wr(8'h00, 32'hFFFF_FFFE);
      @(negedge clk_50m); src_i[0] = 1'b1;
      @(negedge clk_50m); src_i[0] = 1'b0;      // edge 0 done
      @(negedge clk_50m);                       // edge 1
      @(negedge clk_50m);                       // edge 2
      chk("lvl_int_e2", 32'(int_o), 32'd0);
      @(negedge clk_50m);                       // edge 3
      chk("lvl_int_e3", 32'(int_o), 32'd1);
      rd(8'h40, 32'h1, 32'h1, "lvl_status");
      chk("lvl_int_held", 32'(int_o), 32'd1);
      @(negedge clk_50m);
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h40; cfg_wdata = 32'h1;
      @(negedge clk_50m);
      cfg_req = 1'b0; cfg_we = 1'b0;
      chk("w1c_int_ack", 32'(int_o), 32'd1);
      @(negedge clk_50m);
      chk("w1c_int_low", 32'(int_o), 32'd0);

      // bit 40: level capture, switch to edge while high, W1C, re-edge
      @(negedge clk_50m); src_i[40] = 1'b1;
      repeat (4) @(negedge clk_50m);
      rd(8'h44, 32'h100, 32'h100, "b40_level");
      wr(8'h24, 32'h100);
      wr(8'h44, 32'h100);
      repeat (3) @(negedge clk_50m);
      rd(8'h44, 32'h0, 32'h0, "b40_nospur");
      rd(8'h64, 32'h100, 32'h100, "b40_raw");
      src_i[40] = 1'b0;
      repeat (4) @(negedge clk_50m);
      rd(8'h44, 32'h0, 32'h0, "b40_fall");
      src_i[40] = 1'b1;
      repeat (4) @(negedge clk_50m);
      rd(8'h44, 32'h100, 32'h100, "b40_rise");
      src_i[40] = 1'b0;
      wr(8'h44, 32'h100);

      // W1C collides with level set on bit 3: set wins
      wr(8'h00, 32'hFFFF_FFF6);
      @(negedge clk_50m); src_i[3] = 1'b1;
      repeat (4) @(negedge clk_50m);
      chk("b3_int", 32'(int_o), 32'd1);
      wr(8'h40, 32'h8);
      chk("b3_int_ack", 32'(int_o), 32'd1);
      @(negedge clk_50m);
      chk("b3_int_after", 32'(int_o), 32'd1);
      rd(8'h40, 32'h8, 32'h8, "b3_status");
      src_i[3] = 1'b0;
      repeat (3) @(negedge clk_50m);
      wr(8'h40, 32'h8);
      repeat (2) @(negedge clk_50m);
      chk("b3_int_off", 32'(int_o), 32'd0);

      // counter: 3 rises so far, then 5 (saturates at 3 for CNT_W=2)
      pulse_clear(0);
      rd(8'h84, 32'd3, 32'd3, "cnt3");
      pulse_clear(0);
      pulse_clear(0);
      rd(8'h84, 32'd5, 32'd3, "cnt5_sat");
      wr(8'h84, 32'hDEAD);
      rd(8'h84, 32'd0, 32'd0, "cnt_clr");

      // clear lands on the edge int_o rises: clear wins
      @(negedge clk_50m); src_i[0] = 1'b1;
      @(negedge clk_50m); src_i[0] = 1'b0;      // edge 0
      @(negedge clk_50m);                       // edge 1
      @(negedge clk_50m);                       // edge 2
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h84; cfg_wdata = 32'h0;
      @(negedge clk_50m);                       // edge 3: rise + clear
      cfg_req = 1'b0; cfg_we = 1'b0;
      chk("coll_int", 32'(int_o), 32'd1);
      rd(8'h84, 32'd0, 32'd0, "cnt_coll");
      wr(8'h40, 32'h1);
      repeat (2) @(negedge clk_50m);

      // back-to-back write / read / read
      @(negedge clk_50m);
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h00; cfg_wdata = 32'hFFFF_FFFE;
      @(negedge clk_50m);
      chk("b2b_ack0", 32'(cfg_ack), 32'd1);
      chk("b2b_rd0", cfg_rdata, 32'd0);
      cfg_we = 1'b0; cfg_addr = 8'h04;
      @(negedge clk_50m);
      chk("b2b_ack1", 32'(cfg_ack), 32'd1);
      chk("b2b_rd1", cfg_rdata, 32'h0000_FFFF);
      cfg_addr = 8'h88;
      @(negedge clk_50m);
      chk("b2b_ack2", 32'(cfg_ack), 32'd1);
      chk("b2b_rd2", cfg_rdata, 32'd0);
      cfg_req = 1'b0;
      @(negedge clk_50m);
      chk("b2b_ack_end", 32'(cfg_ack), 32'd0);

      // reset in the middle of a write: no ack, state back to reset
      @(negedge clk_50m);
      cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h00; cfg_wdata = 32'h0;
      #2 rstn_50m = 1'b0;
      @(negedge clk_50m);
      chk("mid_rst_ack", 32'(cfg_ack), 32'd0);
      cfg_req = 1'b0; cfg_we = 1'b0;
      @(negedge clk_50m);
      rstn_50m = 1'b1;
      rd(8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mid_rst_mask");
      rd(8'h80, 32'd0, 32'd0, "mid_rst_ctrl");

      repeat (2) @(negedge clk_50m);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gpio_int_mask_bank.md
# gpio_int_mask_bank

Parametrised interrupt source bank for the gpio_int subsystem, generalising the fixed sh/info/err mask registers into one width-configurable block. It holds mask, mode and sticky status for `SRC_W` sources, filters them into a single registered interrupt, and exposes all state through a simple request/acknowledge register port. It is instantiated once per interrupt class (sh, info, err) inside the gpio_int configuration logic.

## Interface

- `SRC_W`, 48: number of interrupt sources, 1..256; registers span `NW = ceil(SRC_W/32)` words.
- `SYNC_EN`, 1: 1 inserts a 2-flop synchroniser on `src_i`; 0 samples `src_i` directly.
- `CNT_W`, 16: width of the saturating interrupt counter, 1..32.

- `clk_50m`  in  1  system clock
- `rstn_50m`  in  1  asynchronous active-low reset
- `src_i`  in  SRC_W  raw interrupt sources, active high
- `cfg_req`  in  1  register access request, one-cycle qualifier
- `cfg_we`  in  1  1 = write, 0 = read
- `cfg_addr`  in  8  byte address, word-aligned; bits [1:0] ignored
- `cfg_wdata`  in  32  write data
- `cfg_rdata`  out  32  read data, valid when `cfg_ack`=1
- `cfg_ack`  out  1  access complete
- `int_o`  out  1  registered interrupt request

## Operation

- Register map, word index `i` in 0..NW-1:
  - 0x00+4i MASK[i]: RW; 1 = source masked.
  - 0x20+4i MODE[i]: RW; 0 = level, 1 = rising edge.
  - 0x40+4i STATUS[i]: read sticky status; write-1-to-clear.
  - 0x60+4i RAW[i]: RO; post-synchroniser source value.
  - 0x80 CTRL: bit0 global enable, RW; other bits read 0.
  - 0x84 INT_CNT: RO count of `int_o` rising edges, saturating at all-ones; any write clears it to 0.
- Bits at or above `SRC_W` in the top word read 0; writes to them are ignored. Unmapped addresses read 0, ignore writes and are still acknowledged.
- Status set: level mode sets the bit every cycle the synced source is 1. Edge mode sets the bit on a synced 0→1 transition. Mask does not gate status capture.
- `int_o` = CTRL.en & |(STATUS & ~MASK), registered.
- Same-cycle W1C and set on one bit: set wins, and the bit stays 1.
- A MODE change takes effect on the next cycle. The edge history flop always tracks the synced source, so switching to edge mode while the source is high does not produce a spurious edge.
- INT_CNT increment and clear in the same cycle: clear wins, and the counter is 0.

## Timing

- Reset values: MASK all ones, MODE 0, STATUS 0, CTRL 0, INT_CNT 0, synchroniser/history flops 0, `int_o` 0, `cfg_ack` 0, `cfg_rdata` 0.
- Register port:
  - `cfg_ack` asserts for exactly one cycle, on the cycle after a sampled `cfg_req`.
  - Back-to-back requests are allowed, one per cycle, and are acknowledged in order.
  - `cfg_rdata` is 0 whenever `cfg_ack`=0.
  - A write takes effect at the clock edge that raises `cfg_ack`.
  - A read returns register state from the cycle `cfg_req` was sampled.
- Source latency, with edge 0 being the first edge that sees `src_i`=1:
  - SYNC_EN=1: STATUS set at edge 2; `int_o` at edge 3.
  - SYNC_EN=0: STATUS set at edge 0; `int_o` at edge 1.
- W1C to the last pending bit: STATUS clears at the ack edge, and `int_o` deasserts one edge later.
- Reset asserted mid-access: the access is dropped with no ack, and all state returns to reset values asynchronously.

## Structure

- Package `gpio_int_pkg` holds:
  - the register offset constants (MASK_BASE, MODE_BASE, STATUS_BASE, RAW_BASE, CTRL_ADDR, CNT_ADDR);
  - the CTRL bit position;
  - a function `nwords(int w)` returning ceil(w/32).
- Sub-module `gpio_int_sync_edge`, vector-wide (`WIDTH`, `SYNC_EN` parameters): optional 2-flop synchroniser plus history flop. Its outputs are the synced level and the rising-edge pulse.
- The top level contains the register file, status logic, address decode, interrupt output and counter.

## Test plan

- Reset, then read all registers -> MASK[0]=0xFFFF_FFFF, MASK[1]=0x0000_FFFF (SRC_W=48), all others 0, `int_o`=0.
- Level mode, CTRL=1, MASK[0]=0xFFFF_FFFE; pulse `src_i[0]` high for 1 cycle -> STATUS[0]=0x1 at edge 2, `int_o` high at edge 3 and held. Write 0x1 to STATUS[0] -> `int_o` low 2 edges after the request.
- Edge mode on bit 40, with `src_i[40]` held high, then W1C -> status stays 0 until `src_i[40]` falls and rises again; RAW[1] bit 8 reads 1 while the source is high.
- W1C to STATUS[0] bit 3 on the same cycle a level source sets bit 3 -> bit reads 1 afterwards, and `int_o` stays asserted.
- Three separate `int_o` assertions, then read INT_CNT -> 3. With CNT_W=2, five assertions -> 3 (saturated). Write INT_CNT -> reads 0.
- Back-to-back write/read/read to 0x00, 0x04, 0x88 -> three consecutive one-cycle acks. The reads return 0x0000_FFFF (MASK[1] reset value) and 0 (unmapped address).
